// File: rtl/ps_pc_seq.sv
// ps_pc_seq: program sequencer with fetch/decode/execute address pipeline and PC stack.
// A redirect costs two execute bubbles; ps_stall freezes every register.
module ps_pc_seq #(
  parameter int            AW        = 16,
  parameter int            STK_DEPTH = 4,
  parameter logic [AW-1:0] RST_VEC   = '0,
  localparam int           SPW       = $clog2(STK_DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ps_stall,
  input  logic           ps_jmp,
  input  logic           ps_call,
  input  logic           ps_rts,
  input  logic [AW-1:0]  ps_tgt,
  input  logic           ps_push,
  input  logic           ps_pop,
  input  logic           ps_idle,
  input  logic           ps_wake,
  input  logic           ps_stk_wen,
  input  logic [AW-1:0]  ps_stk_wdt,
  input  logic           ps_stky_clr,
  output logic [AW-1:0]  ps_faddr,
  output logic [AW-1:0]  ps_daddr,
  output logic [AW-1:0]  ps_pc,
  output logic           ps_ex_vld,
  output logic           ps_pm_cslt,
  output logic [AW-1:0]  ps_stk_top,
  output logic [SPW-1:0] ps_stk_pntr,
  output logic [3:0]     ps_stky
);
  localparam logic [0:0]     S_RUN    = 1'b0;
  localparam logic [0:0]     S_IDLE   = 1'b1;
  localparam logic [SPW-1:0] FULL_CNT = SPW'(STK_DEPTH);

  logic [AW-1:0]  faddr_q, faddr_d, daddr_q, daddr_d, pc_q, pc_d;
  logic           dvld_q, dvld_d, ex_vld_q, ex_vld_d, cslt_q, cslt_d;
  logic [0:0]     state_q, state_d;
  logic [SPW-1:0] pntr_q, pntr_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0]  stk_q [STK_DEPTH];
  logic [AW-1:0]  stk_d [STK_DEPTH];

  logic           stk_empty, stk_full, accept, push_ok, pop_ok;
  logic [SPW-2:0] push_idx, top_idx;
  logic [AW-1:0]  pc_inc;

  assign stk_empty = (pntr_q == '0);
  assign stk_full  = (pntr_q == FULL_CNT);
  assign push_idx  = pntr_q[SPW-2:0];
  // Wraps correctly when full: low bits are zero, minus one selects the last entry.
  assign top_idx   = pntr_q[SPW-2:0] - 1'b1;
  assign pc_inc    = pc_q + 1'b1;
  assign accept    = ex_vld_q & ~ps_stall & (state_q == S_RUN);
  assign push_ok   = ps_push & ~ps_pop;
  assign pop_ok    = ps_pop & ~ps_push;

  always_comb begin
    faddr_d  = faddr_q;
    daddr_d  = daddr_q;
    pc_d     = pc_q;
    dvld_d   = dvld_q;
    ex_vld_d = ex_vld_q;
    cslt_d   = cslt_q;
    state_d  = state_q;
    pntr_d   = pntr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_d    = stk_q;
    if (!ps_stall) begin
      if (state_q == S_RUN) begin
        faddr_d  = faddr_q + 1'b1;
        daddr_d  = faddr_q;
        pc_d     = daddr_q;
        dvld_d   = 1'b1;
        ex_vld_d = dvld_q;
        if (accept) begin
          // Clear first so a same-cycle overflow/underflow set takes precedence.
          if (ps_stky_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
          if (ps_rts) begin
            if (stk_empty) begin
              unf_d = 1'b1;
            end else begin
              faddr_d  = stk_q[top_idx];
              pntr_d   = pntr_q - 1'b1;
              dvld_d   = 1'b0;
              ex_vld_d = 1'b0;
            end
          end else if (ps_call || ps_jmp) begin
            faddr_d  = ps_tgt;
            dvld_d   = 1'b0;
            ex_vld_d = 1'b0;
            if (ps_call) begin
              if (stk_full) begin
                ovf_d = 1'b1;
              end else begin
                stk_d[push_idx] = pc_inc;
                pntr_d          = pntr_q + 1'b1;
              end
            end
          end else begin
            if (push_ok) begin
              if (stk_full) begin
                ovf_d = 1'b1;
              end else begin
                stk_d[push_idx] = pc_inc;
                pntr_d          = pntr_q + 1'b1;
              end
            end else if (pop_ok) begin
              if (stk_empty) unf_d = 1'b1;
              else pntr_d = pntr_q - 1'b1;
            end else if (ps_stk_wen && !stk_empty) begin
              stk_d[top_idx] = ps_stk_wdt;
            end
            if (ps_idle) begin
              state_d  = S_IDLE;
              faddr_d  = pc_inc;
              cslt_d   = 1'b0;
              dvld_d   = 1'b0;
              ex_vld_d = 1'b0;
            end
          end
        end
      end else if (ps_wake) begin
        state_d = S_RUN;
        cslt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      faddr_q  <= RST_VEC;
      daddr_q  <= '0;
      pc_q     <= '0;
      dvld_q   <= 1'b0;
      ex_vld_q <= 1'b0;
      cslt_q   <= 1'b1;
      state_q  <= S_RUN;
      pntr_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      faddr_q  <= faddr_d;
      daddr_q  <= daddr_d;
      pc_q     <= pc_d;
      dvld_q   <= dvld_d;
      ex_vld_q <= ex_vld_d;
      cslt_q   <= cslt_d;
      state_q  <= state_d;
      pntr_q   <= pntr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign ps_faddr    = faddr_q;
  assign ps_daddr    = daddr_q;
  assign ps_pc       = pc_q;
  assign ps_ex_vld   = ex_vld_q;
  assign ps_pm_cslt  = cslt_q;
  assign ps_stk_top  = stk_empty ? '0 : stk_q[top_idx];
  assign ps_stk_pntr = pntr_q;
  assign ps_stky     = {unf_q, ovf_q, stk_full, stk_empty};
endmodule

// File: tb/tb_ps_pc_seq.sv
// Scenario bench for ps_pc_seq: executed addresses are scoreboarded, stack/flag state checked inline.
module tb_ps_pc_seq;
  localparam int            AW        = 16;
  localparam int            STK_DEPTH = 4;
  localparam int            SPW       = 3;
  localparam logic [AW-1:0] RST_VEC   = 16'h0010;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ps_stall = 0, ps_jmp = 0, ps_call = 0, ps_rts = 0;
  logic [AW-1:0]  ps_tgt = '0;
  logic           ps_push = 0, ps_pop = 0, ps_idle = 0, ps_wake = 0, ps_stk_wen = 0;
  logic [AW-1:0]  ps_stk_wdt = '0;
  logic           ps_stky_clr = 0;
  logic [AW-1:0]  ps_faddr, ps_daddr, ps_pc, ps_stk_top;
  logic           ps_ex_vld, ps_pm_cslt;
  logic [SPW-1:0] ps_stk_pntr;
  logic [3:0]     ps_stky;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] stk_model[$];
  logic [AW-1:0] exp_v;

  ps_pc_seq #(.AW(AW), .STK_DEPTH(STK_DEPTH), .RST_VEC(RST_VEC)) dut (
    .clk(clk), .rst(rst), .ps_stall(ps_stall), .ps_jmp(ps_jmp), .ps_call(ps_call),
    .ps_rts(ps_rts), .ps_tgt(ps_tgt), .ps_push(ps_push), .ps_pop(ps_pop),
    .ps_idle(ps_idle), .ps_wake(ps_wake), .ps_stk_wen(ps_stk_wen),
    .ps_stk_wdt(ps_stk_wdt), .ps_stky_clr(ps_stky_clr), .ps_faddr(ps_faddr),
    .ps_daddr(ps_daddr), .ps_pc(ps_pc), .ps_ex_vld(ps_ex_vld), .ps_pm_cslt(ps_pm_cslt),
    .ps_stk_top(ps_stk_top), .ps_stk_pntr(ps_stk_pntr), .ps_stky(ps_stky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [AW-1:0] a);
    int n = 0;
    while (!(ps_ex_vld === 1'b1 && ps_pc === a) && n < 300) begin
      tick();
      n++;
    end
    if (!(ps_ex_vld === 1'b1 && ps_pc === a)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pc: timed out, pc=%h ex_vld=%b, required pc=%h", ps_pc, ps_ex_vld, a);
    end
  endtask

  task automatic redirect(input logic [AW-1:0] t);
    ps_jmp = 1; ps_tgt = t;
    tick();
    ps_jmp = 0;
    wait_pc(t);
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    n_cmp++;
    if ({ps_faddr, ps_daddr, ps_pc} !== {RST_VEC, 16'h0, 16'h0}) begin
      n_bad++; $display("FAIL reset_addr: faddr=%h daddr=%h pc=%h required 0010/0000/0000", ps_faddr, ps_daddr, ps_pc);
    end
    n_cmp++;
    if ({ps_ex_vld, ps_pm_cslt, ps_stk_pntr, ps_stky, ps_stk_top} !== {1'b0, 1'b1, 3'd0, 4'b0001, 16'h0}) begin
      n_bad++; $display("FAIL reset_ctl: ex=%b cslt=%b pntr=%0d stky=%b top=%h", ps_ex_vld, ps_pm_cslt, ps_stk_pntr, ps_stky, ps_stk_top);
    end
    rst = 1;
    tick();
    n_cmp++;
    if ({ps_ex_vld, ps_daddr, ps_faddr} !== {1'b0, 16'h0010, 16'h0011}) begin
      n_bad++; $display("FAIL reset_c1: ex=%b daddr=%h faddr=%h required 0/0010/0011", ps_ex_vld, ps_daddr, ps_faddr);
    end
    tick();
    n_cmp++;
    if ({ps_ex_vld, ps_pc, ps_faddr} !== {1'b1, 16'h0010, 16'h0012}) begin
      n_bad++; $display("FAIL reset_c2: ex=%b pc=%h faddr=%h required 1/0010/0012", ps_ex_vld, ps_pc, ps_faddr);
    end
    for (int i = 1; i <= 4; i++) exp_q.push_back(RST_VEC + AW'(i));
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ps_ex_vld && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (ps_pc !== exp_v) begin n_bad++; $display("FAIL reset_seq: pc=%h required %h", ps_pc, exp_v); end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL reset_seq_drain: %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    ps_jmp = 1; ps_tgt = 16'hFFFE;
    tick();
    ps_jmp = 0;
    n_cmp++;
    if ({ps_faddr, ps_ex_vld} !== {16'hFFFE, 1'b0}) begin
      n_bad++; $display("FAIL wrap_redir: faddr=%h ex=%b required FFFE/0", ps_faddr, ps_ex_vld);
    end
    tick(); tick();
    n_cmp++;
    if ({ps_faddr, ps_ex_vld, ps_pc} !== {16'h0000, 1'b1, 16'hFFFE}) begin
      n_bad++; $display("FAIL wrap_faddr: faddr=%h ex=%b pc=%h required 0000/1/FFFE", ps_faddr, ps_ex_vld, ps_pc);
    end
    exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ps_ex_vld && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (ps_pc !== exp_v) begin n_bad++; $display("FAIL wrap_seq: pc=%h required %h", ps_pc, exp_v); end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_drain: %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_jump();
    wait_pc(16'h0005);
    ps_jmp = 1; ps_tgt = 16'h0100;
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0101);
    tick();
    ps_jmp = 0;
    n_cmp++;
    if (ps_faddr !== 16'h0100) begin n_bad++; $display("FAIL jump_faddr: faddr=%h required 0100", ps_faddr); end
    for (int c = 0; c < 4; c++) begin
      if (c < 2) begin
        n_cmp++;
        if (ps_ex_vld !== 1'b0) begin n_bad++; $display("FAIL jump_bubble: ex=%b cycle %0d required 0", ps_ex_vld, c); end
      end
      tick();
      if (ps_ex_vld && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (ps_pc !== exp_v) begin n_bad++; $display("FAIL jump_seq: pc=%h required %h", ps_pc, exp_v); end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL jump_drain: %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_call_rts();
    redirect(16'h0020);
    ps_call = 1; ps_tgt = 16'h0200;
    tick();
    ps_call = 0;
    n_cmp++;
    if ({ps_faddr, ps_stk_top, ps_stk_pntr, ps_stky} !== {16'h0200, 16'h0021, 3'd1, 4'b0000}) begin
      n_bad++; $display("FAIL call: faddr=%h top=%h pntr=%0d stky=%b required 0200/0021/1/0000", ps_faddr, ps_stk_top, ps_stk_pntr, ps_stky);
    end
    wait_pc(16'h0203);
    ps_rts = 1;
    tick();
    ps_rts = 0;
    n_cmp++;
    if ({ps_faddr, ps_stk_pntr, ps_stky, ps_ex_vld} !== {16'h0021, 3'd0, 4'b0001, 1'b0}) begin
      n_bad++; $display("FAIL rts: faddr=%h pntr=%0d stky=%b ex=%b required 0021/0/0001/0", ps_faddr, ps_stk_pntr, ps_stky, ps_ex_vld);
    end
    tick(); tick();
    n_cmp++;
    if ({ps_ex_vld, ps_pc} !== {1'b1, 16'h0021}) begin
      n_bad++; $display("FAIL rts_exec: ex=%b pc=%h required 1/0021", ps_ex_vld, ps_pc);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] base, tgt;
    base = 16'h0021;
    for (int k = 0; k < 5; k++) begin
      tgt = 16'h0300 + AW'(k * 16);
      wait_pc(base);
      ps_call = 1; ps_tgt = tgt;
      tick();
      ps_call = 0;
      if (k < 4) stk_model.push_back(base + 1'b1);
      n_cmp++;
      if (ps_faddr !== tgt) begin n_bad++; $display("FAIL ovf_redir: faddr=%h required %h", ps_faddr, tgt); end
      if (k == 3) begin
        n_cmp++;
        if ({ps_stk_pntr, ps_stky} !== {3'd4, 4'b0010}) begin
          n_bad++; $display("FAIL full: pntr=%0d stky=%b required 4/0010", ps_stk_pntr, ps_stky);
        end
      end
      base = tgt;
    end
    n_cmp++;
    if ({ps_stk_pntr, ps_stky, ps_stk_top} !== {3'd4, 4'b0110, stk_model[$]}) begin
      n_bad++; $display("FAIL ovf: pntr=%0d stky=%b top=%h required 4/0110/%h", ps_stk_pntr, ps_stky, ps_stk_top, stk_model[$]);
    end
    wait_pc(16'h0340);
    tick(); tick();
    n_cmp++;
    if (ps_stky !== 4'b0110) begin n_bad++; $display("FAIL ovf_hold: stky=%b required 0110", ps_stky); end
    ps_stky_clr = 1;
    tick();
    ps_stky_clr = 0;
    n_cmp++;
    if (ps_stky !== 4'b0010) begin n_bad++; $display("FAIL stky_clr: stky=%b required 0010", ps_stky); end
    ps_stk_wen = 1; ps_stk_wdt = 16'hABCD;
    tick();
    ps_stk_wen = 0;
    stk_model[stk_model.size() - 1] = 16'hABCD;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (ps_stk_top !== stk_model[$]) begin
        n_bad++; $display("FAIL pop_top: top=%h required %h", ps_stk_top, stk_model[$]);
      end
      ps_pop = 1;
      tick();
      ps_pop = 0;
      void'(stk_model.pop_back());
      n_cmp++;
      if ({ps_stk_pntr, ps_ex_vld} !== {SPW'(stk_model.size()), 1'b1}) begin
        n_bad++; $display("FAIL pop_pntr: pntr=%0d ex=%b required %0d/1", ps_stk_pntr, ps_ex_vld, stk_model.size());
      end
    end
    n_cmp++;
    if ({ps_stky, ps_stk_top} !== {4'b0001, 16'h0}) begin
      n_bad++; $display("FAIL drained: stky=%b top=%h required 0001/0000", ps_stky, ps_stk_top);
    end
  endtask

  task automatic test_empty();
    redirect(16'h0500);
    ps_rts = 1;
    tick();
    ps_rts = 0;
    n_cmp++;
    if ({ps_faddr, ps_ex_vld, ps_pc, ps_stky, ps_stk_pntr} !== {16'h0503, 1'b1, 16'h0501, 4'b1001, 3'd0}) begin
      n_bad++; $display("FAIL rts_empty: faddr=%h ex=%b pc=%h stky=%b pntr=%0d required 0503/1/0501/1001/0", ps_faddr, ps_ex_vld, ps_pc, ps_stky, ps_stk_pntr);
    end
    ps_pop = 1;
    tick();
    ps_pop = 0;
    n_cmp++;
    if ({ps_stk_pntr, ps_stky, ps_ex_vld} !== {3'd0, 4'b1001, 1'b1}) begin
      n_bad++; $display("FAIL pop_empty: pntr=%0d stky=%b ex=%b required 0/1001/1", ps_stk_pntr, ps_stky, ps_ex_vld);
    end
    ps_stky_clr = 1;
    tick();
    n_cmp++;
    if (ps_stky !== 4'b0001) begin n_bad++; $display("FAIL unf_clr: stky=%b required 0001", ps_stky); end
    ps_pop = 1;
    tick();
    ps_pop = 0; ps_stky_clr = 0;
    n_cmp++;
    if (ps_stky !== 4'b1001) begin n_bad++; $display("FAIL clr_vs_set: stky=%b required 1001", ps_stky); end
    ps_push = 1; ps_pop = 1;
    tick();
    ps_push = 0; ps_pop = 0;
    n_cmp++;
    if ({ps_stk_pntr, ps_stky} !== {3'd0, 4'b1001}) begin
      n_bad++; $display("FAIL push_pop: pntr=%0d stky=%b required 0/1001", ps_stk_pntr, ps_stky);
    end
    ps_stky_clr = 1;
    tick();
    ps_stky_clr = 0;
    wait_pc(16'h0506);
    ps_push = 1;
    tick();
    ps_push = 0;
    n_cmp++;
    if ({ps_stk_top, ps_stk_pntr, ps_stky} !== {16'h0507, 3'd1, 4'b0000}) begin
      n_bad++; $display("FAIL push: top=%h pntr=%0d stky=%b required 0507/1/0000", ps_stk_top, ps_stk_pntr, ps_stky);
    end
    ps_pop = 1;
    tick();
    ps_pop = 0;
  endtask

  task automatic test_stall();
    redirect(16'h0600);
    ps_stall = 1; ps_jmp = 1; ps_tgt = 16'h0700;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({ps_faddr, ps_daddr, ps_pc, ps_ex_vld} !== {16'h0602, 16'h0601, 16'h0600, 1'b1}) begin
        n_bad++; $display("FAIL stall_hold: faddr=%h daddr=%h pc=%h ex=%b required 0602/0601/0600/1", ps_faddr, ps_daddr, ps_pc, ps_ex_vld);
      end
    end
    ps_stall = 0; ps_jmp = 0;
    tick();
    n_cmp++;
    if ({ps_pc, ps_faddr} !== {16'h0601, 16'h0603}) begin
      n_bad++; $display("FAIL stall_release: pc=%h faddr=%h required 0601/0603", ps_pc, ps_faddr);
    end
  endtask

  task automatic test_idle();
    redirect(16'h0030);
    ps_idle = 1;
    tick();
    ps_idle = 0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({ps_pm_cslt, ps_faddr, ps_ex_vld} !== {1'b0, 16'h0031, 1'b0}) begin
        n_bad++; $display("FAIL idle_hold: cslt=%b faddr=%h ex=%b cycle %0d required 0/0031/0", ps_pm_cslt, ps_faddr, ps_ex_vld, c);
      end
      tick();
    end
    ps_stall = 1; ps_wake = 1;
    tick();
    ps_stall = 0; ps_wake = 0;
    n_cmp++;
    if (ps_pm_cslt !== 1'b0) begin n_bad++; $display("FAIL idle_stall: cslt=%b required 0", ps_pm_cslt); end
    ps_wake = 1;
    tick();
    ps_wake = 0;
    n_cmp++;
    if ({ps_pm_cslt, ps_faddr, ps_ex_vld} !== {1'b1, 16'h0031, 1'b0}) begin
      n_bad++; $display("FAIL wake: cslt=%b faddr=%h ex=%b required 1/0031/0", ps_pm_cslt, ps_faddr, ps_ex_vld);
    end
    tick(); tick();
    n_cmp++;
    if ({ps_ex_vld, ps_pc} !== {1'b1, 16'h0031}) begin
      n_bad++; $display("FAIL wake_exec: ex=%b pc=%h required 1/0031", ps_ex_vld, ps_pc);
    end
  endtask

  task automatic test_reset_idle();
    redirect(16'h0040);
    ps_push = 1;
    tick();
    ps_push = 0;
    ps_idle = 1;
    tick();
    ps_idle = 0;
    tick();
    n_cmp++;
    if ({ps_pm_cslt, ps_stk_pntr} !== {1'b0, 3'd1}) begin
      n_bad++; $display("FAIL pre_rst: cslt=%b pntr=%0d required 0/1", ps_pm_cslt, ps_stk_pntr);
    end
    rst = 0;
    #1;
    n_cmp++;
    if ({ps_faddr, ps_daddr, ps_pc, ps_ex_vld, ps_pm_cslt, ps_stk_pntr, ps_stky, ps_stk_top}
        !== {RST_VEC, 16'h0, 16'h0, 1'b0, 1'b1, 3'd0, 4'b0001, 16'h0}) begin
      n_bad++; $display("FAIL rst_idle: faddr=%h daddr=%h pc=%h ex=%b cslt=%b pntr=%0d stky=%b top=%h", ps_faddr, ps_daddr, ps_pc, ps_ex_vld, ps_pm_cslt, ps_stk_pntr, ps_stky, ps_stk_top);
    end
    tick();
    rst = 1;
    tick(); tick();
    n_cmp++;
    if ({ps_ex_vld, ps_pc} !== {1'b1, RST_VEC}) begin
      n_bad++; $display("FAIL rst_restart: ex=%b pc=%h required 1/0010", ps_ex_vld, ps_pc);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_jump();
    test_call_rts();
    test_overflow();
    test_empty();
    test_stall();
    test_idle();
    test_reset_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
